// File: rtl/mux_rr_sched.sv
// -----------------------------------------------------------------------------
// mux_rr_sched
//   Round-robin scheduler driving the select input of a 2**SELECT_LINES:1 mux.
//   The winning source index is registered onto `select`. The downstream
//   consumer takes the mux output through a valid/ready handshake
//   (sel_valid / out_ready). A source keeps the grant for up to DWELL accepted
//   transfers. After that the priority pointer moves past it, so one busy
//   source cannot starve the others.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   req        in   [N-1:0] per-source request, N = 2**SELECT_LINES
//   out_ready  in   downstream accepts the current mux output
//   select     out  [SELECT_LINES-1:0] registered index of the granted source
//   grant      out  [N-1:0] registered one-hot of select while sel_valid
//   sel_valid  out  registered; mux output on select is valid
//   ack        out  [N-1:0] combinational; equals grant in transfer cycles
// -----------------------------------------------------------------------------
module mux_rr_sched #(
    parameter int SELECT_LINES = 4,
    parameter int DWELL        = 1,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [(2**SELECT_LINES)-1:0]   req,
    input  logic                           out_ready,
    output logic [SELECT_LINES-1:0]        select,
    output logic [(2**SELECT_LINES)-1:0]   grant,
    output logic                           sel_valid,
    output logic [(2**SELECT_LINES)-1:0]   ack
);

    localparam int N = 2**SELECT_LINES;

    // Counter value seen on the last transfer of a dwell window.
    localparam logic [CNT_WIDTH-1:0]    LP_CNT_LAST = CNT_WIDTH'(DWELL - 1);
    localparam logic [CNT_WIDTH-1:0]    LP_CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [SELECT_LINES-1:0] LP_SEL_ONE  = SELECT_LINES'(1);
    localparam logic [N-1:0]            LP_BIT0     = N'(1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t                  r_state;
    logic [SELECT_LINES-1:0] r_select;
    logic [SELECT_LINES-1:0] r_ptr;
    logic [CNT_WIDTH-1:0]    r_cnt;
    logic                    r_sel_valid;
    logic [N-1:0]            r_grant;

    state_t                  w_state_nxt;
    logic [SELECT_LINES-1:0] w_select_nxt;
    logic [SELECT_LINES-1:0] w_ptr_nxt;
    logic [CNT_WIDTH-1:0]    w_cnt_nxt;
    logic                    w_valid_nxt;
    logic [N-1:0]            w_grant_nxt;

    logic                    w_any_req;
    logic                    w_xfer;
    logic                    w_cur_req;
    logic                    w_burst_end;
    logic [SELECT_LINES-1:0] w_rot_ptr;
    logic [SELECT_LINES-1:0] w_arb_ptr;
    logic [SELECT_LINES-1:0] w_arb_rot;

    // First requester found by walking upward from p. The index arithmetic
    // is SELECT_LINES wide, so it wraps modulo N with no explicit compare.
    function automatic logic [SELECT_LINES-1:0] arb(
        input logic [N-1:0]            r,
        input logic [SELECT_LINES-1:0] p
    );
        logic [SELECT_LINES-1:0] res;
        logic [SELECT_LINES-1:0] idx;
        logic                    found;
        res   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = p + SELECT_LINES'(k);
            if (!found && r[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    assign w_any_req   = |req;
    assign w_xfer      = r_sel_valid & out_ready;
    assign w_cur_req   = req[r_select];
    assign w_burst_end = (r_cnt == LP_CNT_LAST) || !w_cur_req;
    assign w_rot_ptr   = r_select + LP_SEL_ONE;
    assign w_arb_ptr   = arb(req, r_ptr);
    // Search from the slot after the finishing source. The finishing source
    // is visited last, so it is re-granted only when it is the sole requester.
    assign w_arb_rot   = arb(req, w_rot_ptr);

    always_comb begin
        w_state_nxt  = r_state;
        w_select_nxt = r_select;
        w_ptr_nxt    = r_ptr;
        w_cnt_nxt    = r_cnt;
        w_valid_nxt  = r_sel_valid;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_select_nxt = w_arb_ptr;
                    w_valid_nxt  = 1'b1;
                    w_cnt_nxt    = '0;
                    w_state_nxt  = S_GRANT;
                end
            end
            S_GRANT: begin
                if (w_xfer) begin
                    if (w_burst_end) begin
                        w_ptr_nxt = w_rot_ptr;
                        if (w_any_req) begin
                            // Back-to-back grant: no bubble between sources.
                            w_select_nxt = w_arb_rot;
                            w_cnt_nxt    = '0;
                        end else begin
                            w_valid_nxt = 1'b0;
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + LP_CNT_ONE;
                    end
                end else if (!w_cur_req) begin
                    // The source withdrew before it was served. Drop the grant
                    // without an ack and keep the pointer. IDLE then
                    // re-arbitrates, which costs one bubble cycle.
                    w_valid_nxt = 1'b0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_valid_nxt = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
        w_grant_nxt = w_valid_nxt ? (LP_BIT0 << w_select_nxt) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_select    <= '0;
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_sel_valid <= 1'b0;
            r_grant     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_select    <= w_select_nxt;
            r_ptr       <= w_ptr_nxt;
            r_cnt       <= w_cnt_nxt;
            r_sel_valid <= w_valid_nxt;
            r_grant     <= w_grant_nxt;
        end
    end

    assign select    = r_select;
    assign sel_valid = r_sel_valid;
    assign grant     = r_grant;
    assign ack       = w_xfer ? r_grant : '0;

endmodule

// File: tb/tb_mux_rr_sched.sv
module tb_mux_rr_sched;

    logic        clk;
    logic        rst;
    logic [15:0] req1, req3;
    logic        rdy1, rdy3;
    logic [3:0]  sel1, sel3;
    logic [15:0] gnt1, gnt3, ack1, ack3;
    logic        vld1, vld3;

    int total = 0;
    int bad   = 0;

    mux_rr_sched #(.SELECT_LINES(4), .DWELL(1), .CNT_WIDTH(8)) u_d1 (
        .clk(clk), .rst(rst), .req(req1), .out_ready(rdy1),
        .select(sel1), .grant(gnt1), .sel_valid(vld1), .ack(ack1)
    );

    mux_rr_sched #(.SELECT_LINES(4), .DWELL(3), .CNT_WIDTH(8)) u_d3 (
        .clk(clk), .rst(rst), .req(req3), .out_ready(rdy3),
        .select(sel3), .grant(gnt3), .sel_valid(vld3), .ack(ack3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: one record per instance (0: DWELL=1, 1: DWELL=3).
    int m_ptr[2];
    int m_sel[2];
    int m_cnt[2];
    bit m_vld[2];
    int m_dw[2] = '{1, 3};

    typedef struct {
        int          inst;
        logic [15:0] req;
        logic        rdy;
        logic [15:0] ack;
        logic        vld;
        int          sel;
    } vec_t;
    vec_t tv[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // The winner is the requester at the smallest cyclic distance from p.
    function automatic int arb(input logic [15:0] r, input int p);
        int best;
        int bd;
        best = -1;
        bd   = 16;
        for (int i = 0; i < 16; i++) begin
            if (r[i]) begin
                int d;
                d = (i - p + 16) % 16;
                if (d < bd) begin
                    bd   = d;
                    best = i;
                end
            end
        end
        return best;
    endfunction

    function automatic logic [15:0] onehot(input int s);
        logic [15:0] v;
        v = '0;
        v[s] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_ptr[k] = 0; m_sel[k] = 0; m_cnt[k] = 0; m_vld[k] = 1'b0;
        end
    endtask

    task automatic model_update(input int k, input logic [15:0] r, input logic rdy);
        if (!m_vld[k]) begin
            if (r != 0) begin
                m_sel[k] = arb(r, m_ptr[k]);
                m_vld[k] = 1'b1;
                m_cnt[k] = 0;
            end
        end else if (rdy) begin
            if (m_cnt[k] == m_dw[k] - 1 || !r[m_sel[k]]) begin
                m_ptr[k] = (m_sel[k] + 1) % 16;
                if (r != 0) begin
                    m_sel[k] = arb(r, m_ptr[k]);
                    m_cnt[k] = 0;
                end else begin
                    m_vld[k] = 1'b0;
                end
            end else begin
                m_cnt[k]++;
            end
        end else if (!r[m_sel[k]]) begin
            m_vld[k] = 1'b0;
        end
    endtask

    function automatic logic [15:0] m_ack(input int k, input logic rdy);
        return (m_vld[k] && rdy) ? onehot(m_sel[k]) : 16'h0;
    endfunction

    function automatic logic [15:0] m_gnt(input int k);
        return m_vld[k] ? onehot(m_sel[k]) : 16'h0;
    endfunction

    task automatic model_check_regs();
        chk("d1.valid", 32'(vld1), 32'(m_vld[0]));
        chk("d1.grant", 32'(gnt1), 32'(m_gnt(0)));
        if (m_vld[0]) chk("d1.select", 32'(sel1), 32'(m_sel[0]));
        chk("d3.valid", 32'(vld3), 32'(m_vld[1]));
        chk("d3.grant", 32'(gnt3), 32'(m_gnt(1)));
        if (m_vld[1]) chk("d3.select", 32'(sel3), 32'(m_sel[1]));
    endtask

    // Called at a negedge with inputs already driven. It checks the ack,
    // clocks the model, and checks the registered outputs at the next negedge.
    task automatic tick();
        #1;
        chk("d1.ack", 32'(ack1), 32'(m_ack(0, rdy1)));
        chk("d3.ack", 32'(ack3), 32'(m_ack(1, rdy3)));
        @(posedge clk);
        model_update(0, req1, rdy1);
        model_update(1, req3, rdy3);
        @(negedge clk);
        model_check_regs();
    endtask

    task automatic add(input int inst, input logic [15:0] r, input logic rdy,
                       input logic [15:0] a, input logic v, input int s);
        vec_t e;
        e.inst = inst; e.req = r; e.rdy = rdy; e.ack = a; e.vld = v; e.sel = s;
        tv.push_back(e);
    endtask

    initial begin
        // DWELL=1: single source, idle, round robin, wrap, backpressure.
        add(0, 16'h0004, 1, 16'h0000, 1, 2);
        add(0, 16'h0004, 1, 16'h0004, 1, 2);
        add(0, 16'h0004, 1, 16'h0004, 1, 2);
        add(0, 16'h0000, 0, 16'h0000, 0, 0);
        add(0, 16'h0000, 1, 16'h0000, 0, 0);
        add(0, 16'h8421, 1, 16'h0000, 1, 5);
        add(0, 16'h8421, 1, 16'h0020, 1, 10);
        add(0, 16'h8421, 1, 16'h0400, 1, 15);
        add(0, 16'h8421, 1, 16'h8000, 1, 0);
        add(0, 16'h8421, 1, 16'h0001, 1, 5);
        add(0, 16'h4000, 1, 16'h0020, 1, 14);
        add(0, 16'h0003, 1, 16'h4000, 1, 0);
        add(0, 16'h0003, 1, 16'h0001, 1, 1);
        add(0, 16'h0003, 1, 16'h0002, 1, 0);
        add(0, 16'h0000, 0, 16'h0000, 0, 0);
        add(0, 16'h0030, 0, 16'h0000, 1, 4);
        for (int i = 0; i < 4; i++) add(0, 16'h0030, 0, 16'h0000, 1, 4);
        add(0, 16'h0030, 1, 16'h0010, 1, 5);
        add(0, 16'h0030, 1, 16'h0020, 1, 4);
        // DWELL=3: three transfers per source, then withdrawal with a bubble.
        add(1, 16'h0003, 1, 16'h0000, 1, 0);
        add(1, 16'h0003, 1, 16'h0001, 1, 0);
        add(1, 16'h0003, 1, 16'h0001, 1, 0);
        add(1, 16'h0003, 1, 16'h0001, 1, 1);
        add(1, 16'h0003, 1, 16'h0002, 1, 1);
        add(1, 16'h0003, 1, 16'h0002, 1, 1);
        add(1, 16'h0003, 1, 16'h0002, 1, 0);
        add(1, 16'h0003, 1, 16'h0001, 1, 0);
        add(1, 16'h0003, 1, 16'h0001, 1, 0);
        add(1, 16'h0003, 1, 16'h0001, 1, 1);
        add(1, 16'h0001, 0, 16'h0000, 0, 0);
        add(1, 16'h0001, 0, 16'h0000, 1, 0);
        add(1, 16'h0001, 1, 16'h0001, 1, 0);
        add(1, 16'h0000, 1, 16'h0001, 0, 0);
        add(1, 16'h0000, 0, 16'h0000, 0, 0);

        rst = 1'b1;
        req1 = '0; req3 = '0; rdy1 = 1'b0; rdy3 = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst.select", 32'(sel1), 32'h0);
        chk("rst.valid", 32'(vld1), 32'h0);
        chk("rst.grant", 32'(gnt1), 32'h0);
        chk("rst.ack", 32'(ack1), 32'h0);
        rst = 1'b0;

        for (int k = 0; k < tv.size(); k++) begin
            if (tv[k].inst == 0) begin
                req1 = tv[k].req; rdy1 = tv[k].rdy; req3 = '0; rdy3 = 1'b0;
                #1 chk($sformatf("tv%0d.ack", k), 32'(ack1), 32'(tv[k].ack));
            end else begin
                req3 = tv[k].req; rdy3 = tv[k].rdy; req1 = '0; rdy1 = 1'b0;
                #1 chk($sformatf("tv%0d.ack", k), 32'(ack3), 32'(tv[k].ack));
            end
            tick();
            if (tv[k].inst == 0) begin
                chk($sformatf("tv%0d.valid", k), 32'(vld1), 32'(tv[k].vld));
                if (tv[k].vld) chk($sformatf("tv%0d.select", k), 32'(sel1), 32'(tv[k].sel));
            end else begin
                chk($sformatf("tv%0d.valid", k), 32'(vld3), 32'(tv[k].vld));
                if (tv[k].vld) chk($sformatf("tv%0d.select", k), 32'(sel3), 32'(tv[k].sel));
            end
        end

        // Reset mid-burst: outputs clear before the next clock edge.
        req1 = 16'h0030; rdy1 = 1'b0; req3 = 16'h0003; rdy3 = 1'b0;
        tick();
        chk("midrst.pre_valid", 32'(vld1), 32'h1);
        rdy1 = 1'b1; rdy3 = 1'b1; rst = 1'b1;
        #1;
        chk("midrst.select", 32'(sel1), 32'h0);
        chk("midrst.valid", 32'(vld1), 32'h0);
        chk("midrst.grant", 32'(gnt1), 32'h0);
        chk("midrst.ack", 32'(ack1), 32'h0);
        chk("midrst.ack3", 32'(ack3), 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            logic [15:0] r;
            r = 16'($urandom) & 16'($urandom);
            if ($urandom_range(0, 3) == 0) r = 16'h0;
            req1 = r;
            rdy1 = ($urandom_range(0, 3) != 0);
            r = 16'($urandom) & 16'($urandom) & 16'($urandom);
            req3 = (c % 16 < 12) ? (req3 | r) & 16'($urandom) | req3 & 16'h00ff : r;
            rdy3 = ($urandom_range(0, 2) != 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_rr_sched.md
Name: mux_rr_sched

Overview:
- Round-robin scheduler that sits directly upstream of the mux and drives its select input.
- Arbitrates among 2**SELECT_LINES requesting sources and presents the winning index on select.
- Uses a valid/ready handshake to the downstream consumer of the mux output.
- Grants up to DWELL consecutive transfers per source before rotating, so one busy source cannot starve the others.

Parameters:
- SELECT_LINES, 4: width of select; number of sources N = 2**SELECT_LINES.
- DWELL, 1: maximum accepted transfers per grant before rotation (>=1).
- CNT_WIDTH, 8: width of the internal dwell counter; must satisfy DWELL <= 2**CNT_WIDTH.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  N  per-source request; bit i high means source i has data on its mux slice.
- out_ready  in  1  downstream can accept the current mux output.
- select  out  SELECT_LINES  registered mux select; index of the granted source.
- grant  out  N  registered one-hot of select while sel_valid=1, else all zero.
- sel_valid  out  1  registered; the mux output on select is valid.
- ack  out  N  combinational one-hot pulse, equal to grant when sel_valid & out_ready (transfer).

Behaviour:
- Reset (async, immediate): select=0, grant=0, sel_valid=0; priority pointer ptr=0; burst count=0; state=IDLE. Reset mid-burst drops the grant with no ack.
- Transfer: a cycle with sel_valid=1 and out_ready=1. ack is asserted only in transfer cycles.
- Arbitration function ARB(ptr): first i with req[i]=1, searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (wraps modulo N).
- State IDLE:
  - If |req, register select=ARB(ptr), set sel_valid=1, count=0, and go to GRANT.
  - Latency from req to sel_valid is 1 cycle.
- State GRANT, transfer cycle:
  - count increments.
  - If count==DWELL-1 or req[select]==0 in that cycle, the grant ends and ptr becomes (select+1) mod N.
  - If any req is still high, the next grant is registered on the same edge with no bubble. The finished source has lowest priority but can be re-granted if it is the only requester.
  - Otherwise sel_valid drops and the state returns to IDLE.
  - If the grant does not end, select holds and sel_valid stays 1.
- State GRANT, no transfer:
  - select and sel_valid hold stable while out_ready=0 and req[select]=1.
  - Withdrawal: if req[select]=0 and there is no transfer, the grant is dropped next cycle with no ack. ptr is unchanged. Re-arbitration proceeds as in IDLE on the following cycle, so there is one bubble.
- Count width: the dwell counter is CNT_WIDTH bits; DWELL=1 rotates after every transfer.
- Multiple simultaneous requests: exactly one grant bit at a time; grant is never non-one-hot.
- req changes on sources other than select never disturb a held grant.

Test Plan:
- Reset: assert rst mid-simulation with sel_valid=1 -> select=0, sel_valid=0, grant=0, ack=0 immediately, before the next clk edge.
- Single source: SELECT_LINES=4, DWELL=1, req=0x0004, out_ready=1 -> select=2, sel_valid=1 one cycle later; ack=0x0004 every cycle with no bubble.
- Round robin: DWELL=1, req=0x8421, out_ready=1 -> select sequence 0,5,10,15,0,... with one transfer each and no bubbles.
- Wrap-around: ptr=15 after a grant to 14, req=0x0003 -> next select=0, then 1.
- Backpressure: req=0x0030, out_ready=0 for 5 cycles -> select=4 stable, sel_valid=1, ack=0. Raise out_ready -> one ack=0x0010, then select=5.
- Dwell and withdrawal:
  - DWELL=3, req=0x0003, out_ready=1 -> three transfers on select 0, then three on 1.
  - Drop req[1] while out_ready=0 -> sel_valid=0 next cycle with no ack; select=0 regranted the cycle after.
